alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Byte-level command sequencer for the registered 8-bit ALU in the system datapath.
//  - Parses command frames arriving from the UART RX side.
//  - Loads operands and function code into the ALU and issues a single-cycle EN.
//  - Captures the 16-bit result on OUT_VALID and returns it to the UART TX side as two bytes.
//  - Sits between the RX/TX byte interfaces and the ALU; it is the only master of ALU EN.
// PARAMETERS
//  DATA_WIDTH  8   operand / byte width
//  OUT_WIDTH   16  ALU result width (must be 2*DATA_WIDTH)
//  FUN_WIDTH   4   ALU function-code width
// PORTS
//  CLK            in   1           single system clock, rising edge
//  RST            in   1           asynchronous, active-low reset
//  RX_P_DATA      in   DATA_WIDTH  received byte
//  RX_D_VLD       in   1           1-cycle strobe, RX_P_DATA valid
//  ALU_A          out  DATA_WIDTH  operand A register
//  ALU_B          out  DATA_WIDTH  operand B register
//  ALU_FUN        out  FUN_WIDTH   function-code register
//  ALU_EN         out  1           1-cycle ALU enable pulse
//  ALU_OUT        in   OUT_WIDTH   ALU result
//  ALU_OUT_VALID  in   1           ALU result valid (1 cycle after ALU_EN)
//  TX_P_DATA      out  DATA_WIDTH  byte to transmit
//  TX_D_VLD       out  1           TX byte valid; held until accepted
//  TX_BUSY        in   1           TX cannot accept; byte accepted when TX_D_VLD & ~TX_BUSY
//  CMD_ERR        out  1           1-cycle pulse: unknown command byte
//  RX_DROP        out  1           1-cycle pulse: RX byte arrived while not parsing
//  SEQ_BUSY       out  1           high in every state except IDLE
// BEHAVIOUR
//  - Reset (RST=0, async): FSM->IDLE; all outputs and operand/result registers 0.
//    Applies mid-frame and mid-transmit; the partial frame is discarded.
//  - Frames (first byte = command):
//    0xCC = A, B, FUN (3 payload bytes).
//    0xDD = FUN only; reuses the held A/B.
//  - FUN byte: bits [FUN_WIDTH-1:0] are used; upper bits are ignored. Every code is executed.
//  - FSM states: IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, ALU_WAIT, TX_LO, TX_HI.
//    IDLE:     RX_D_VLD & 0xCC->GET_A; 0xDD->GET_FUN; any other byte -> CMD_ERR pulse, stay.
//    GET_A:    RX_D_VLD -> load ALU_A -> GET_B.
//    GET_B:    RX_D_VLD -> load ALU_B -> GET_FUN.
//    GET_FUN:  RX_D_VLD -> load ALU_FUN -> ALU_RUN.
//    ALU_RUN:  ALU_EN=1 for exactly this cycle -> ALU_WAIT.
//    ALU_WAIT: on ALU_OUT_VALID, capture ALU_OUT into result register -> TX_LO.
//    TX_LO:    TX_P_DATA=result[7:0], TX_D_VLD=1; on accept -> TX_HI.
//    TX_HI:    TX_P_DATA=result[15:8], TX_D_VLD=1; on accept -> IDLE.
//  - Latency: FUN byte strobed at edge t -> ALU_EN high cycle t+1 -> result captured at t+2
//    -> TX_D_VLD high from cycle t+3.
//  - TX_P_DATA/TX_D_VLD stay stable while TX_BUSY=1.
//  - TX_D_VLD drops the cycle after the high byte is accepted.
//  - RX_D_VLD in ALU_RUN/ALU_WAIT/TX_LO/TX_HI: byte ignored, RX_DROP pulses, FSM unaffected.
//  - ALU_OUT_VALID outside ALU_WAIT: ignored.
//  - ALU_A/B/FUN hold their value between frames. ALU_EN is never asserted outside ALU_RUN.
//  - All outputs are driven from registers. Next-state logic is combinational; state is registered.
// STRUCTURE
//  - Shared package alu_seq_pkg: CMD_ALU_W_OP=8'hCC, CMD_ALU_NO_OP=8'hDD,
//    FSM state enum/encoding, ALU function-code constants (ADD=0, SUB=1, MUL=2, DIV=3, ...).
//  - No sub-module: a single FSM plus operand, result and TX registers.
// TESTING
//  1. RX 0xCC,0x05,0x03,0x00 -> ALU_EN one pulse with A=5, B=3, FUN=0; TX 0x08 then 0x00; SEQ_BUSY low after.
//  2. Follow with 0xDD,0x02 -> A/B reused, result 0x000F; TX 0x0F then 0x00.
//  3. 0xCC,0xFF,0xFF,0x02 with TX_BUSY=1 for 10 cycles -> TX_D_VLD/0x01 held stable; then 0xFE sent.
//  4. 0x55 in IDLE -> CMD_ERR pulses 1 cycle, no ALU_EN, FSM stays IDLE.
//  5. RX byte 0x77 during TX_LO -> RX_DROP pulse; transmitted bytes unchanged.
//  6. RST low during GET_B (after A=0x09) -> outputs 0 at once; then 0xDD,0x00 -> TX 0x00, 0x00.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared definitions for the ALU command sequencer: default
//               widths, command opcodes, FSM state encoding and ALU function
//               codes.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int SEQ_DATA_WIDTH = 8;
    localparam int SEQ_OUT_WIDTH  = 16;
    localparam int SEQ_FUN_WIDTH  = 4;

    // Command bytes (first byte of a frame)
    localparam logic [7:0] CMD_ALU_W_OP  = 8'hCC;   // A, B, FUN follow
    localparam logic [7:0] CMD_ALU_NO_OP = 8'hDD;   // FUN only, reuse A/B

    // ALU function codes
    localparam logic [3:0] ALU_FUN_ADD = 4'h0;
    localparam logic [3:0] ALU_FUN_SUB = 4'h1;
    localparam logic [3:0] ALU_FUN_MUL = 4'h2;
    localparam logic [3:0] ALU_FUN_DIV = 4'h3;
    localparam logic [3:0] ALU_FUN_AND = 4'h4;
    localparam logic [3:0] ALU_FUN_OR  = 4'h5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_A    = 3'd1,
        ST_GET_B    = 3'd2,
        ST_GET_FUN  = 3'd3,
        ST_ALU_RUN  = 3'd4,
        ST_ALU_WAIT = 3'd5,
        ST_TX_LO    = 3'd6,
        ST_TX_HI    = 3'd7
    } seq_state_t;

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer_if
// Description : Byte/ALU bus of the command sequencer.
//               master : the sequencer (drives ALU operands/EN, TX byte, status)
//               slave  : the environment (RX byte source, ALU, TX sink)
//   rx_p_data/rx_d_vld     : received byte + 1-cycle strobe
//   alu_a/alu_b/alu_fun    : operand and function-code registers
//   alu_en                 : 1-cycle ALU enable
//   alu_out/alu_out_valid  : ALU result and its valid strobe
//   tx_p_data/tx_d_vld     : byte to transmit, held until accepted
//   tx_busy                : TX cannot accept
//   cmd_err/rx_drop        : 1-cycle error pulses
//   seq_busy               : sequencer not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_cmd_sequencer_if
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = SEQ_DATA_WIDTH,
    parameter int OUT_WIDTH  = SEQ_OUT_WIDTH,
    parameter int FUN_WIDTH  = SEQ_FUN_WIDTH
);
    logic [DATA_WIDTH-1:0] rx_p_data;
    logic                  rx_d_vld;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [FUN_WIDTH-1:0]  alu_fun;
    logic                  alu_en;
    logic [OUT_WIDTH-1:0]  alu_out;
    logic                  alu_out_valid;
    logic [DATA_WIDTH-1:0] tx_p_data;
    logic                  tx_d_vld;
    logic                  tx_busy;
    logic                  cmd_err;
    logic                  rx_drop;
    logic                  seq_busy;

    modport master (
        input  rx_p_data, rx_d_vld, alu_out, alu_out_valid, tx_busy,
        output alu_a, alu_b, alu_fun, alu_en, tx_p_data, tx_d_vld,
               cmd_err, rx_drop, seq_busy
    );

    modport slave (
        output rx_p_data, rx_d_vld, alu_out, alu_out_valid, tx_busy,
        input  alu_a, alu_b, alu_fun, alu_en, tx_p_data, tx_d_vld,
               cmd_err, rx_drop, seq_busy
    );

endinterface : alu_cmd_sequencer_if
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Parses 0xCC (A,B,FUN) / 0xDD (FUN) command frames from the
//               RX byte stream, fires the ALU for one cycle, captures the
//               16-bit result and returns it low byte first to TX.
// Ports       : clk    - system clock, rising edge
//               rst_n  - asynchronous active-low reset
//               bus    - alu_cmd_sequencer_if.master (RX, ALU, TX, status)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = SEQ_DATA_WIDTH,
    parameter int OUT_WIDTH  = SEQ_OUT_WIDTH,
    parameter int FUN_WIDTH  = SEQ_FUN_WIDTH
)
(
    input  wire logic           clk,
    input  wire logic           rst_n,
    alu_cmd_sequencer_if.master bus
);

    seq_state_t r_state;
    seq_state_t w_state_nxt;

    logic [DATA_WIDTH-1:0] r_alu_a,   w_alu_a_nxt;
    logic [DATA_WIDTH-1:0] r_alu_b,   w_alu_b_nxt;
    logic [FUN_WIDTH-1:0]  r_alu_fun, w_alu_fun_nxt;
    logic [OUT_WIDTH-1:0]  r_result,  w_result_nxt;
    logic [DATA_WIDTH-1:0] r_tx_data, w_tx_data_nxt;
    logic                  w_cmd_err_nxt;
    logic                  w_rx_drop_nxt;
    logic                  r_alu_en;
    logic                  r_tx_vld;
    logic                  r_cmd_err;
    logic                  r_rx_drop;
    logic                  r_seq_busy;
    logic                  w_tx_accept;

    assign w_tx_accept = r_tx_vld & ~bus.tx_busy;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-value logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_alu_a_nxt   = r_alu_a;
        w_alu_b_nxt   = r_alu_b;
        w_alu_fun_nxt = r_alu_fun;
        w_result_nxt  = r_result;
        w_tx_data_nxt = r_tx_data;
        w_cmd_err_nxt = 1'b0;
        w_rx_drop_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.rx_d_vld) begin
                    if (bus.rx_p_data == DATA_WIDTH'(CMD_ALU_W_OP)) begin
                        w_state_nxt = ST_GET_A;
                    end else if (bus.rx_p_data == DATA_WIDTH'(CMD_ALU_NO_OP)) begin
                        w_state_nxt = ST_GET_FUN;
                    end else begin
                        w_cmd_err_nxt = 1'b1;
                    end
                end
            end
            ST_GET_A: begin
                if (bus.rx_d_vld) begin
                    w_alu_a_nxt = bus.rx_p_data;
                    w_state_nxt = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (bus.rx_d_vld) begin
                    w_alu_b_nxt = bus.rx_p_data;
                    w_state_nxt = ST_GET_FUN;
                end
            end
            ST_GET_FUN: begin
                if (bus.rx_d_vld) begin
                    // Only the low bits select the function; the rest are ignored
                    w_alu_fun_nxt = bus.rx_p_data[FUN_WIDTH-1:0];
                    w_state_nxt   = ST_ALU_RUN;
                end
            end
            ST_ALU_RUN: begin
                w_rx_drop_nxt = bus.rx_d_vld;
                w_state_nxt   = ST_ALU_WAIT;
            end
            ST_ALU_WAIT: begin
                w_rx_drop_nxt = bus.rx_d_vld;
                if (bus.alu_out_valid) begin
                    w_result_nxt  = bus.alu_out;
                    // Low byte is loaded together with the result so TX can
                    // present it the very next cycle
                    w_tx_data_nxt = bus.alu_out[DATA_WIDTH-1:0];
                    w_state_nxt   = ST_TX_LO;
                end
            end
            ST_TX_LO: begin
                w_rx_drop_nxt = bus.rx_d_vld;
                if (w_tx_accept) begin
                    w_tx_data_nxt = r_result[OUT_WIDTH-1:DATA_WIDTH];
                    w_state_nxt   = ST_TX_HI;
                end
            end
            ST_TX_HI: begin
                w_rx_drop_nxt = bus.rx_d_vld;
                if (w_tx_accept) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath registers. Strobes are decoded from the next state
    // so that every output comes straight from a flop.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_fun  <= '0;
            r_result   <= '0;
            r_tx_data  <= '0;
            r_alu_en   <= 1'b0;
            r_tx_vld   <= 1'b0;
            r_cmd_err  <= 1'b0;
            r_rx_drop  <= 1'b0;
            r_seq_busy <= 1'b0;
        end else begin
            r_alu_a    <= w_alu_a_nxt;
            r_alu_b    <= w_alu_b_nxt;
            r_alu_fun  <= w_alu_fun_nxt;
            r_result   <= w_result_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_alu_en   <= (w_state_nxt == ST_ALU_RUN);
            r_tx_vld   <= (w_state_nxt == ST_TX_LO) || (w_state_nxt == ST_TX_HI);
            r_cmd_err  <= w_cmd_err_nxt;
            r_rx_drop  <= w_rx_drop_nxt;
            r_seq_busy <= (w_state_nxt != ST_IDLE);
        end
    end

    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_fun   = r_alu_fun;
    assign bus.alu_en    = r_alu_en;
    assign bus.tx_p_data = r_tx_data;
    assign bus.tx_d_vld  = r_tx_vld;
    assign bus.cmd_err   = r_cmd_err;
    assign bus.rx_drop   = r_rx_drop;
    assign bus.seq_busy  = r_seq_busy;

endmodule : alu_cmd_sequencer
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Scoreboard bench for alu_cmd_sequencer. Stimulus pushes the
//               expected ALU operands and TX bytes; a monitor pops and
//               compares whenever the DUT fires ALU_EN or hands over a byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

    logic clk;
    logic rst_n;

    alu_cmd_sequencer_if #(.DATA_WIDTH(8), .OUT_WIDTH(16), .FUN_WIDTH(4)) bus ();

    alu_cmd_sequencer #(.DATA_WIDTH(8), .OUT_WIDTH(16), .FUN_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_tx  [$];
    logic [19:0] exp_alu [$];     // {A, B, FUN}
    int          n_cmd_err = 0;
    int          n_rx_drop = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Registered ALU model: result and valid one cycle after EN
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_out       <= 16'h0000;
            bus.alu_out_valid <= 1'b0;
        end else begin
            bus.alu_out_valid <= bus.alu_en;
            if (bus.alu_en) begin
                case (bus.alu_fun)
                    4'h0:    bus.alu_out <= 16'(bus.alu_a) + 16'(bus.alu_b);
                    4'h1:    bus.alu_out <= 16'(bus.alu_a) - 16'(bus.alu_b);
                    4'h2:    bus.alu_out <= 16'(bus.alu_a) * 16'(bus.alu_b);
                    default: bus.alu_out <= 16'h0000;
                endcase
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic       held;
        logic [7:0] held_data;
        logic       prev_err;
        logic       prev_drop;
        logic [7:0] e8;
        logic [19:0] e20;
        held = 1'b0; held_data = 8'h00; prev_err = 1'b0; prev_drop = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0; prev_err = 1'b0; prev_drop = 1'b0;
            end else begin
                if (held)
                    check("tx_hold", 32'({bus.tx_d_vld, bus.tx_p_data}), 32'({1'b1, held_data}));
                held      = bus.tx_d_vld && bus.tx_busy;
                held_data = bus.tx_p_data;
                if (bus.tx_d_vld && !bus.tx_busy) begin
                    if (exp_tx.size() == 0) begin
                        check("tx_unexpected", 32'(bus.tx_p_data), 32'hFFFF_FFFF);
                    end else begin
                        e8 = exp_tx.pop_front();
                        check("tx_byte", 32'(bus.tx_p_data), 32'(e8));
                    end
                end
                if (bus.alu_en) begin
                    if (exp_alu.size() == 0) begin
                        check("alu_en_unexpected", 32'({bus.alu_a, bus.alu_b, bus.alu_fun}), 32'hFFFF_FFFF);
                    end else begin
                        e20 = exp_alu.pop_front();
                        check("alu_operands", 32'({bus.alu_a, bus.alu_b, bus.alu_fun}), 32'(e20));
                    end
                end
                if (bus.cmd_err) n_cmd_err++;
                if (bus.rx_drop) n_rx_drop++;
                if (prev_err && bus.cmd_err)  check("cmd_err_width", 32'd2, 32'd1);
                if (prev_drop && bus.rx_drop) check("rx_drop_width", 32'd2, 32'd1);
                prev_err  = bus.cmd_err;
                prev_drop = bus.rx_drop;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_p_data = b;
        bus.rx_d_vld  = 1'b1;
        @(posedge clk); #1;
        bus.rx_d_vld  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus.seq_busy && exp_tx.size() == 0 && exp_alu.size() == 0) return;
        end
        check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_tx_vld(input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.tx_d_vld) return;
        end
        check(name, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b0;
        bus.rx_p_data  = 8'h00;
        bus.rx_d_vld   = 1'b0;
        bus.tx_busy    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              32'({bus.alu_a, bus.alu_b, bus.alu_fun, bus.alu_en, bus.tx_d_vld,
                   bus.cmd_err, bus.rx_drop, bus.seq_busy}), 32'h0);
        check("reset_tx_data", 32'(bus.tx_p_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: full frame, ADD 5+3
        exp_alu.push_back({8'h05, 8'h03, 4'h0});
        exp_tx.push_back(8'h08); exp_tx.push_back(8'h00);
        send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03);
        send_byte(8'h00);
        check("en_latency", 32'(bus.alu_en), 32'd1);
        @(posedge clk); #1;
        check("tx_not_yet_valid", 32'(bus.tx_d_vld), 32'd0);
        @(posedge clk); #1;
        check("tx_latency", 32'({bus.tx_d_vld, bus.tx_p_data}), 32'h108);
        wait_idle("t1_timeout");
        @(negedge clk);
        check("t1_idle_after", 32'({bus.seq_busy, bus.tx_d_vld}), 32'd0);

        // 2: FUN-only frame reuses A/B, MUL 5*3 (upper FUN bits ignored)
        exp_alu.push_back({8'h05, 8'h03, 4'h2});
        exp_tx.push_back(8'h0F); exp_tx.push_back(8'h00);
        send_byte(8'hDD); send_byte(8'hF2);
        wait_idle("t2_timeout");

        // 3: 0xFF*0xFF with TX back-pressure
        bus.tx_busy = 1'b1;
        exp_alu.push_back({8'hFF, 8'hFF, 4'h2});
        exp_tx.push_back(8'h01); exp_tx.push_back(8'hFE);
        send_byte(8'hCC); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
        wait_tx_vld("t3_tx_vld_timeout");
        repeat (10) @(posedge clk);
        #1;
        bus.tx_busy = 1'b0;
        wait_idle("t3_timeout");

        // 4: unknown command
        send_byte(8'h55);
        @(negedge clk);
        check("t4_stay_idle", 32'(bus.seq_busy), 32'd0);
        repeat (3) @(negedge clk);
        check("t4_cmd_err_count", 32'(n_cmd_err), 32'd1);

        // 5: RX byte during TX_LO is dropped; ADD 1+2
        bus.tx_busy = 1'b1;
        exp_alu.push_back({8'h01, 8'h02, 4'h0});
        exp_tx.push_back(8'h03); exp_tx.push_back(8'h00);
        send_byte(8'hCC); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
        wait_tx_vld("t5_tx_vld_timeout");
        send_byte(8'h77);
        @(negedge clk);
        check("t5_rx_drop_count", 32'(n_rx_drop), 32'd1);
        @(posedge clk); #1;
        bus.tx_busy = 1'b0;
        wait_idle("t5_timeout");

        // 6: async reset mid-frame, then FUN-only frame on cleared A/B
        send_byte(8'hCC); send_byte(8'h09);
        check("t6_a_loaded", 32'({bus.alu_a, bus.seq_busy}), 32'h013);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_reset",
              32'({bus.alu_a, bus.alu_b, bus.alu_fun, bus.seq_busy, bus.tx_d_vld}), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_alu.push_back({8'h00, 8'h00, 4'h0});
        exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
        send_byte(8'hDD); send_byte(8'h00);
        wait_idle("t6_timeout");

        repeat (3) @(negedge clk);
        check("final_cmd_err_count", 32'(n_cmd_err), 32'd1);
        check("final_rx_drop_count", 32'(n_rx_drop), 32'd1);
        check("final_queues_empty", 32'(exp_tx.size() + exp_alu.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_cmd_sequencer
`default_nettype wire
